// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned INSTR_W = 18;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t RESET_PC = 14'h0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// 16-bit saturating event counter used for fetch performance monitoring.
module fetch_perf_counter (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over valid/ready and holds one instruction.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Clear,
  input  logic         isJump,
  input  addr_t        JumpAddress,
  input  logic         Consume,
  output instr_t       Instruction,
  output logic         InstrValid,
  output addr_t        PC,
  output logic         imem_req_valid,
  output addr_t        imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  instr_t       imem_rsp_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  StallCycles,
  output logic [15:0]  FetchCount
`endif
);

  fetch_state_t state_q, state_d;
  addr_t        fetch_pc_q, fetch_pc_d;
  addr_t        pc_q, pc_d;
  instr_t       instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         rsp_latch;
  logic         consume_hold;

  // A response is only kept when it arrives in WAIT and no restart is requested.
  assign rsp_latch    = (state_q == WAIT) && imem_rsp_valid && !Clear;
  assign consume_hold = (state_q == HOLD) && Consume && !Clear;

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (Clear) begin
          state_d = imem_req_ready ? DROP : IDLE;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = Clear ? REQ : HOLD;
        end else if (Clear) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (Clear || Consume) begin
          state_d = REQ;
        end
      end
      // Wait out the orphaned response before issuing the restart fetch.
      DROP: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    if (state_q == REQ) begin
      imem_req_valid = 1'b1;
      imem_req_addr  = fetch_pc_q;
    end
  end

  // Datapath next-state: latch, redirect, restart (restart wins).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    if (rsp_latch) begin
      instr_d    = imem_rsp_data;
      pc_d       = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + addr_t'(1);
    end
    if (consume_hold) begin
      valid_d = 1'b0;
      if (isJump) begin
        fetch_pc_d = JumpAddress;
      end
    end
    if (Clear) begin
      valid_d    = 1'b0;
      fetch_pc_d = RESET_PC;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PC          = pc_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_stall_cnt (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (!valid_q),
    .count   (StallCycles)
  );

  fetch_perf_counter u_fetch_cnt (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (rsp_latch),
    .count   (FetchCount)
  );
`endif

endmodule
